instruction_queue: RTL
======================

// Module: instruction_queue
// PURPOSE
//  Parametrised multi-entry instruction register/prefetch queue. Sits between instruction memory and control unit.
//  Buffers up to DEPTH fetched words with a valid/ready handshake on both sides.
//  Presents the head entry split into ir_opcode / ir_operand_or_addr; flush discards all entries (branch/jump).
// PARAMETERS
//  OPCODE_W   4  opcode field width (instruction MSBs)
//  OPERAND_W  8  operand/address field width (instruction LSBs)
//  DEPTH      4  entries; power of two, >=2
//  INSTR_W    OPCODE_W+OPERAND_W  derived (localparam), full instruction width
//  CNT_W      $clog2(DEPTH+1)     derived (localparam), occupancy width
// PORTS
//  clk                 in   1          clock, all logic on rising edge
//  reset_ir_n          in   1          synchronous reset, active-low
//  flush               in   1          synchronous discard of all entries
//  in_valid            in   1          instruction word offered
//  in_ready            out  1          queue can accept (count<DEPTH)
//  instruction         in   INSTR_W    fetched word
//  out_valid           out  1          head entry present (count!=0)
//  out_ready           in   1          consumer takes head this cycle
//  ir_opcode           out  OPCODE_W   head[INSTR_W-1:OPERAND_W]; 0 when !out_valid
//  ir_operand_or_addr  out  OPERAND_W  head[OPERAND_W-1:0]; 0 when !out_valid
//  count               out  CNT_W      current occupancy
// BEHAVIOUR
//  - One clock, synchronous active-low reset on reset_ir_n; no asynchronous paths.
//  - Reset (reset_ir_n=0 at edge): wr_ptr=rd_ptr=0, count=0, all storage cleared to 0.
//    Hence in_ready=1, out_valid=0, ir_* = 0. Reset wins over flush, push, pop.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready depends only on count; no comb path from out_ready.
//    Push to full queue impossible even if pop same cycle.
//  - push: mem[wr_ptr]<=instruction, wr_ptr+1 mod DEPTH.
//  - pop: rd_ptr+1 mod DEPTH.
//  - count: +1 push only, -1 pop only, unchanged both/neither.
//  - Pointers wrap naturally (log2(DEPTH) bits); count disambiguates full/empty.
//  - Latency: pushed word visible on ir_* / out_valid the cycle after push edge (1 cycle); no fall-through.
//  - Outputs combinational from mem[rd_ptr] gated by out_valid; stable while out_valid & !out_ready.
//  - flush (reset_ir_n=1): pointers and count -> 0 next edge.
//    Any same-cycle push is dropped; storage contents not cleared.
//  - pop when empty / push when full: ignored (handshake blocks); state unchanged.
//  - Reset or flush mid-stream: in-flight entries lost; next push lands at index 0.
// CONFIGURATION
//  IR_PARITY_EN defined:
//    - adds port instruction_parity in 1 (even parity over instruction) and stores it per entry.
//    - adds port parity_err out 1 = out_valid & (^head_word ^ head_parity); combinational, 0 when empty.
//    - stored parity bit cleared on reset.
//  IR_PARITY_EN undefined: ports absent, no extra storage; behaviour otherwise identical.
// TESTING
//  1 Reset: reset_ir_n=0 one edge with prior data -> count=0, out_valid=0, in_ready=1, ir_opcode=0, ir_operand_or_addr=0.
//  2 Order: push 12'hA15,12'h3C7,12'h0FF, out_ready=0
//    -> count=3, ir_opcode=4'hA/operand=8'h15; pop x3 -> 4'h3/8'hC7 then 4'h0/8'hFF then out_valid=0.
//  3 Full/wrap: DEPTH=4, push 5 words with out_ready=0 -> in_ready=0 after 4th, 5th not stored.
//    Pop 2, push 2 -> FIFO order kept across pointer wrap, count=4.
//  4 Simultaneous: count=2, in_valid=1 & out_ready=1 same edge -> count stays 2, head advances, new word at tail.
//  5 Flush: count=3, flush=1 with in_valid=1 (12'h123) -> next cycle count=0, out_valid=0.
//    Next push 12'h456 appears as 4'h4/8'h56.
//  6 IR_PARITY_EN: push 12'h001 with instruction_parity=0 -> parity_err=1 at head; with parity=1 -> 0. Macro off: build compiles without ports.

Source files
------------

// File: rtl/instruction_queue.sv
// instruction_queue
//   Multi-entry instruction register / prefetch queue between instruction
//   memory and the control unit. Valid/ready handshake on both sides; the
//   head entry is presented split into opcode and operand/address fields.
//   Optional feature macro: IR_PARITY_EN (per-entry even parity + error flag).
//
// Ports
//   clk                 in   rising-edge clock
//   reset_ir_n          in   synchronous reset, active-low
//   flush               in   discard all entries (branch/jump)
//   in_valid/in_ready   in/out  producer handshake, in_ready = count<DEPTH
//   instruction         in   fetched word
//   out_valid/out_ready out/in  consumer handshake, out_valid = count!=0
//   ir_opcode           out  head MSB field, 0 when empty
//   ir_operand_or_addr  out  head LSB field, 0 when empty
//   count               out  occupancy
//   instruction_parity  in   (IR_PARITY_EN) even parity of instruction
//   parity_err          out  (IR_PARITY_EN) head parity check failed
module instruction_queue #(
  parameter int OPCODE_W  = 4,
  parameter int OPERAND_W = 8,
  parameter int DEPTH     = 4,
  localparam int INSTR_W  = OPCODE_W + OPERAND_W,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_ir_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   instruction,
`ifdef IR_PARITY_EN
  input  logic                 instruction_parity,
  output logic                 parity_err,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPCODE_W-1:0]  ir_opcode,
  output logic [OPERAND_W-1:0] ir_operand_or_addr,
  output logic [CNT_W-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] head;

`ifdef IR_PARITY_EN
  logic               par_mem [DEPTH];
`endif

  // in_ready looks only at count, so a pop cannot open a slot in the same
  // cycle for a push into a full queue.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset_ir_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
`ifdef IR_PARITY_EN
        par_mem[i] <= 1'b0;
`endif
      end
    end else if (flush) begin
      // Storage is left as-is; only the bookkeeping is discarded.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= instruction;
`ifdef IR_PARITY_EN
        par_mem[wr_ptr] <= instruction_parity;
`endif
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head               = mem[rd_ptr];
  assign ir_opcode          = out_valid ? head[INSTR_W-1:OPERAND_W] : '0;
  assign ir_operand_or_addr = out_valid ? head[OPERAND_W-1:0]       : '0;

`ifdef IR_PARITY_EN
  assign parity_err = out_valid & ((^head) ^ par_mem[rd_ptr]);
`endif

endmodule
